// File: rtl/ddr_frame_rd_ctrl_if.sv
// DDR read-channel and FIFO write-port bundle for the frame read master.
// master = burst controller side, slave = DDR / FIFO side.
interface ddr_frame_rd_ctrl_if #(
  parameter int ADDR_WIDTH       = 28,
  parameter int DATA_WIDTH       = 256,
  parameter int FIFO_DEPTH_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0]     araddr;
  logic [7:0]                arlen;
  logic                      arvalid;
  logic                      arready;
  logic [DATA_WIDTH-1:0]     rdata;
  logic                      rvalid;
  logic                      rlast;
  logic                      rready;
  logic [DATA_WIDTH-1:0]     fifo_wr_data;
  logic                      fifo_wr_en;
  logic [FIFO_DEPTH_WIDTH:0] fifo_wr_level;

  modport master (
    output araddr, arlen, arvalid, rready, fifo_wr_data, fifo_wr_en,
    input  arready, rdata, rvalid, rlast, fifo_wr_level
  );

  modport slave (
    input  araddr, arlen, arvalid, rready, fifo_wr_data, fifo_wr_en,
    output arready, rdata, rvalid, rlast, fifo_wr_level
  );
endinterface

// File: rtl/ddr_frame_rd_ctrl.sv
// Frame read burst master: walks a DDR frame buffer and streams beats into the FIFO (ping/pong via DDR_FRAME_PINGPONG_EN).
// Latency: one cycle from accepted read beat to fifo_wr_en; bursts are issued in order, one outstanding.
// Backpressure: a burst is issued only when the FIFO can absorb all of it, so rready never stalls mid-burst.
module ddr_frame_rd_ctrl #(
  parameter int ADDR_WIDTH       = 28,
  parameter int DATA_WIDTH       = 256,
  parameter int BURST_LEN        = 16,
  parameter int FIFO_DEPTH_WIDTH = 8,
  parameter int BEATS_WIDTH      = 20,
  parameter logic [ADDR_WIDTH-1:0] FRAME_OFFSET = 28'h0200000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame_start,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic [BEATS_WIDTH-1:0] frame_beats,
  output logic                   busy,
  ddr_frame_rd_ctrl_if.master    rd
);

  localparam int LEN_W = 9;
  localparam int LVL_W = FIFO_DEPTH_WIDTH + 10;
  localparam logic [LEN_W-1:0]      MAX_LEN    = LEN_W'(BURST_LEN);
  localparam logic [LVL_W-1:0]      FIFO_DEPTH = LVL_W'(2**FIFO_DEPTH_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] BEAT_BYTES = ADDR_WIDTH'(DATA_WIDTH/8);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ADDR,
    S_DATA,
    S_SETTLE
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  cur_addr_q, cur_addr_d;
  logic [BEATS_WIDTH-1:0] remaining_q, remaining_d;
  logic [LEN_W-1:0]       burst_len_q, burst_len_d;
  logic                   settle_q, settle_d;
  logic                   pend_q, pend_d;
  logic [ADDR_WIDTH-1:0]  pend_addr_q, pend_addr_d;
  logic [BEATS_WIDTH-1:0] pend_beats_q, pend_beats_d;
  logic                   busy_q, busy_d;
  logic [ADDR_WIDTH-1:0]  araddr_q, araddr_d;
  logic [7:0]             arlen_q, arlen_d;
  logic                   arvalid_q, arvalid_d;
  logic                   rready_q, rready_d;
  logic [DATA_WIDTH-1:0]  wr_data_q, wr_data_d;
  logic                   wr_en_q, wr_en_d;

  logic                   frame_sel;
  logic [ADDR_WIDTH-1:0]  fs_addr;
  logic [LEN_W-1:0]       len_c;
  logic                   room_c;
  logic                   beat_hs;
  logic                   load_frame;
  logic [ADDR_WIDTH-1:0]  load_addr;
  logic [BEATS_WIDTH-1:0] load_beats;

`ifdef DDR_FRAME_PINGPONG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_sel <= 1'b0;
    end else if (frame_start) begin
      frame_sel <= ~frame_sel;
    end
  end
`else
  assign frame_sel = 1'b0;
`endif

  assign fs_addr = base_addr + (frame_sel ? FRAME_OFFSET : '0);
  assign len_c   = (remaining_q >= BEATS_WIDTH'(BURST_LEN)) ? MAX_LEN : LEN_W'(remaining_q);
  assign room_c  = (LVL_W'(rd.fifo_wr_level) + LVL_W'(len_c)) <= FIFO_DEPTH;
  assign beat_hs = rd.rvalid && rready_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cur_addr_q   <= '0;
      remaining_q  <= '0;
      burst_len_q  <= '0;
      settle_q     <= 1'b0;
      pend_q       <= 1'b0;
      pend_addr_q  <= '0;
      pend_beats_q <= '0;
      busy_q       <= 1'b0;
      araddr_q     <= '0;
      arlen_q      <= '0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      wr_data_q    <= '0;
      wr_en_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      remaining_q  <= remaining_d;
      burst_len_q  <= burst_len_d;
      settle_q     <= settle_d;
      pend_q       <= pend_d;
      pend_addr_q  <= pend_addr_d;
      pend_beats_q <= pend_beats_d;
      busy_q       <= busy_d;
      araddr_q     <= araddr_d;
      arlen_q      <= arlen_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      wr_data_q    <= wr_data_d;
      wr_en_q      <= wr_en_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    remaining_d  = remaining_q;
    burst_len_d  = burst_len_q;
    settle_d     = settle_q;
    pend_d       = pend_q;
    pend_addr_d  = pend_addr_q;
    pend_beats_d = pend_beats_q;
    busy_d       = busy_q;
    araddr_d     = araddr_q;
    arlen_d      = arlen_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    wr_data_d    = wr_data_q;
    wr_en_d      = 1'b0;
    load_frame   = 1'b0;
    load_addr    = fs_addr;
    load_beats   = frame_beats;

    // A frame request while busy is parked; the newest request always wins.
    if (frame_start && (state_q != S_IDLE)) begin
      pend_d       = 1'b1;
      pend_addr_d  = fs_addr;
      pend_beats_d = frame_beats;
    end

    case (state_q)
      S_IDLE: begin
        load_frame = frame_start;
      end

      S_CHECK: begin
        if (pend_q) begin
          // Abandon the old frame before it issues another burst.
          load_frame = 1'b1;
          load_addr  = pend_addr_q;
          load_beats = pend_beats_q;
          pend_d     = frame_start;
        end else if (room_c) begin
          araddr_d    = cur_addr_q;
          arlen_d     = 8'(len_c - 1'b1);
          arvalid_d   = 1'b1;
          burst_len_d = len_c;
          state_d     = S_ADDR;
        end
      end

      S_ADDR: begin
        if (rd.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_DATA;
        end
      end

      S_DATA: begin
        if (beat_hs) begin
          wr_data_d = rd.rdata;
          wr_en_d   = 1'b1;
          if (rd.rlast) begin
            rready_d    = 1'b0;
            remaining_d = remaining_q - BEATS_WIDTH'(burst_len_q);
            cur_addr_d  = cur_addr_q + ADDR_WIDTH'(burst_len_q) * BEAT_BYTES;
            settle_d    = 1'b0;
            state_d     = S_SETTLE;
          end
        end
      end

      S_SETTLE: begin
        // Two idle cycles let the FIFO level catch up with the last writes.
        if (!settle_q) begin
          settle_d = 1'b1;
        end else if (frame_start) begin
          load_frame = 1'b1;
          pend_d     = 1'b0;
        end else if (pend_q) begin
          load_frame = 1'b1;
          load_addr  = pend_addr_q;
          load_beats = pend_beats_q;
          pend_d     = 1'b0;
        end else if (remaining_q == '0) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          state_d = S_CHECK;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (load_frame) begin
      cur_addr_d  = load_addr;
      remaining_d = load_beats;
      if (load_beats == '0) begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end else begin
        busy_d  = 1'b1;
        state_d = S_CHECK;
      end
    end
  end

  assign busy            = busy_q;
  assign rd.araddr       = araddr_q;
  assign rd.arlen        = arlen_q;
  assign rd.arvalid      = arvalid_q;
  assign rd.rready       = rready_q;
  assign rd.fifo_wr_data = wr_data_q;
  assign rd.fifo_wr_en   = wr_en_q;

endmodule

// File: tb/tb_ddr_frame_rd_ctrl.sv
// Scoreboard bench for ddr_frame_rd_ctrl: directed frames, queued expected bursts/beats,
// negedge monitor pops and compares every AR handshake and FIFO write.
module tb_ddr_frame_rd_ctrl;

  logic        clk;
  logic        tb_rst;
  logic        frame_start;
  logic [27:0] base_addr;
  logic [19:0] frame_beats;
  logic        busy;
  logic        fsel;

  int n_cmp = 0;
  int n_err = 0;

  logic [35:0]  exp_ar[$];
  logic [255:0] exp_wr[$];

  ddr_frame_rd_ctrl_if #(.ADDR_WIDTH(28), .DATA_WIDTH(256), .FIFO_DEPTH_WIDTH(8)) bus ();

  ddr_frame_rd_ctrl #(
    .ADDR_WIDTH(28), .DATA_WIDTH(256), .BURST_LEN(16),
    .FIFO_DEPTH_WIDTH(8), .BEATS_WIDTH(20), .FRAME_OFFSET(28'h0200000)
  ) dut (
    .clk(clk),
    .rst(tb_rst),
    .frame_start(frame_start),
    .base_addr(base_addr),
    .frame_beats(frame_beats),
    .busy(busy),
    .rd(bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [27:0] eff(input logic [27:0] b);
`ifdef DDR_FRAME_PINGPONG_EN
    return fsel ? b + 28'h0200000 : b;
`else
    return b;
`endif
  endfunction

  task automatic exp_burst(input logic [27:0] a, input int len);
    logic [31:0] w;
    exp_ar.push_back({a, 8'(len - 1)});
    for (int i = 0; i < len; i++) begin
      w = 32'(a) + 32'(i) * 32;
      exp_wr.push_back({8{w}});
    end
  endtask

  task automatic pulse(input logic [27:0] b, input logic [19:0] n);
    base_addr   = b;
    frame_beats = n;
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    fsel = ~fsel;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int k = 0;
    while (busy && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    chk(nm, busy, 1'b0);
  endtask

  // DDR slave: one-cycle latency, beat data encodes the beat byte address.
  initial begin
    logic [27:0] a;
    logic [31:0] w;
    int          n;
    bus.rvalid = 1'b0;
    bus.rlast  = 1'b0;
    bus.rdata  = '0;
    forever begin
      @(negedge clk);
      if (!tb_rst && bus.arvalid && bus.arready) begin
        a = bus.araddr;
        n = int'(bus.arlen) + 1;
        @(posedge clk); #1;
        for (int i = 0; i < n; i++) begin
          w = 32'(a) + 32'(i) * 32;
          bus.rvalid = 1'b1;
          bus.rdata  = {8{w}};
          bus.rlast  = (i == n - 1);
          @(posedge clk); #1;
        end
        bus.rvalid = 1'b0;
        bus.rlast  = 1'b0;
      end
    end
  end

  // Scoreboard monitor.
  initial begin
    logic [35:0]  ea;
    logic [255:0] ew;
    forever begin
      @(negedge clk);
      if (!tb_rst) begin
        if (bus.arvalid && bus.arready) begin
          if (exp_ar.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL ar_unexpected: araddr %h arlen %h with no burst expected", bus.araddr, bus.arlen);
          end else begin
            ea = exp_ar.pop_front();
            chk("ar_addr", bus.araddr, ea[35:8]);
            chk("ar_len", bus.arlen, ea[7:0]);
          end
        end
        if (bus.fifo_wr_en) begin
          if (exp_wr.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL wr_unexpected: data %h with no write expected", bus.fifo_wr_data);
          end else begin
            ew = exp_wr.pop_front();
            chk("wr_data", bus.fifo_wr_data, ew);
          end
        end
      end
    end
  end

  initial begin
    logic [27:0] a;
    logic [27:0] b;
    logic [27:0] pp[3];
    int          k;
    tb_rst            = 1'b1;
    frame_start       = 1'b0;
    base_addr         = '0;
    frame_beats       = '0;
    fsel              = 1'b0;
    bus.arready       = 1'b1;
    bus.fifo_wr_level = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_arvalid", bus.arvalid, 1'b0);
    chk("rst_rready", bus.rready, 1'b0);
    chk("rst_wr_en", bus.fifo_wr_en, 1'b0);
    chk("rst_araddr", bus.araddr, 28'h0);
    chk("rst_arlen", bus.arlen, 8'h0);
    chk("rst_wr_data", bus.fifo_wr_data, 256'h0);
    tb_rst = 1'b0;
    @(posedge clk); #1;

    // 40-beat frame: 16 + 16 + 8.
    exp_burst(eff(28'h0100000), 16);
    exp_burst(eff(28'h0100200), 16);
    exp_burst(eff(28'h0100400), 8);
    pulse(28'h0100000, 20'd40);
    chk("t1_busy_rise", busy, 1'b1);
    wait_idle("t1_busy_fall", 500);
    chk("t1_wr_drained", exp_wr.size(), 0);

    // FIFO nearly full: 250+16 > 256 holds, 240+16 == 256 issues.
    bus.fifo_wr_level = 9'd250;
    exp_burst(eff(28'h0300000), 16);
    pulse(28'h0300000, 20'd16);
    repeat (10) begin @(posedge clk); #1; end
    chk("t2_hold_arvalid", bus.arvalid, 1'b0);
    chk("t2_hold_busy", busy, 1'b1);
    bus.fifo_wr_level = 9'd240;
    @(posedge clk); #1;
    chk("t2_issue_arvalid", bus.arvalid, 1'b1);
    wait_idle("t2_busy_fall", 200);
    bus.fifo_wr_level = '0;

    // arready stalled: address phase must hold; 5 beats -> arlen 4.
    bus.arready = 1'b0;
    a = eff(28'h0400000);
    exp_burst(a, 5);
    pulse(28'h0400000, 20'd5);
    k = 0;
    while (!bus.arvalid && k < 20) begin @(posedge clk); #1; k++; end
    chk("t3_arvalid_seen", bus.arvalid, 1'b1);
    repeat (5) begin
      chk("t3_stall_araddr", bus.araddr, a);
      chk("t3_stall_arlen", bus.arlen, 8'd4);
      chk("t3_stall_arvalid", bus.arvalid, 1'b1);
      @(posedge clk); #1;
    end
    bus.arready = 1'b1;
    wait_idle("t3_busy_fall", 200);

    // Empty frame.
    pulse(28'h0500000, 20'd0);
    chk("t4_busy_now", busy, 1'b0);
    repeat (8) begin @(posedge clk); #1; end
    chk("t4_arvalid", bus.arvalid, 1'b0);
    chk("t4_busy_later", busy, 1'b0);

    // Restart during second burst of a 64-beat frame.
    a = eff(28'h0600000);
    exp_burst(a, 16);
    exp_burst(a + 28'h200, 16);
    pulse(28'h0600000, 20'd64);
    k = 0;
    for (int c = 0; c < 400 && k < 2; c++) begin
      @(negedge clk);
      if (bus.arvalid && bus.arready) k++;
    end
    chk("t5_two_bursts", k, 2);
    @(posedge clk); #1;
    repeat (4) begin @(posedge clk); #1; end
    b = eff(28'h0200000);
    exp_burst(b, 16);
    pulse(28'h0200000, 20'd16);
    chk("t5_busy_held", busy, 1'b1);
    wait_idle("t5_busy_fall", 600);

    // Consecutive frames from base 0 after a fresh reset.
    tb_rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    tb_rst = 1'b0;
    fsel   = 1'b0;
    @(posedge clk); #1;
`ifdef DDR_FRAME_PINGPONG_EN
    pp[0] = 28'h0000000; pp[1] = 28'h0200000; pp[2] = 28'h0000000;
`else
    pp[0] = 28'h0000000; pp[1] = 28'h0000000; pp[2] = 28'h0000000;
`endif
    for (int f = 0; f < 3; f++) begin
      exp_burst(pp[f], 1);
      pulse(28'h0000000, 20'd1);
      wait_idle("t6_busy_fall", 100);
    end

    repeat (4) begin @(posedge clk); #1; end
    chk("end_ar_queue_empty", exp_ar.size(), 0);
    chk("end_wr_queue_empty", exp_wr.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
